// File: rtl/nettap_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nettap_dma_pkg
// Description : Shared beat/descriptor types, write-state encoding and a
//               tkeep popcount helper for the MM2S packet path.
// Revision    : 1.0
// ============================================================================
package nettap_dma_pkg;

    localparam int unsigned c_pkt_len_w = 16;

    typedef struct packed {
        logic [3:0]  tkeep;
        logic [31:0] tdata;
    } axis32_beat_t;

    typedef struct packed {
        logic [c_pkt_len_w-1:0] bytes;
        logic [c_pkt_len_w-1:0] beats;
    } pkt_desc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] keep);
        return 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axis_sync_fifo
// Description : Single-clock first-word-fall-through FIFO; a push into a full
//               FIFO is accepted when a pop happens in the same cycle.
// Revision    : 1.0
// ============================================================================
module axis_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                       (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_pop     = i_rd_en && !o_empty;
    assign w_push    = i_wr_en && (!o_full || w_pop);
    assign o_rd_data = r_mem[r_rd_ptr[c_addr_w-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/mm2s_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mm2s_pkt_fifo
// Description : Store-and-forward AXI-Stream packet buffer; only complete,
//               non-empty packets that fit are replayed, with length up front.
// Revision    : 1.0
// ============================================================================
module mm2s_pkt_fifo
    import nettap_dma_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int MAX_PKTS = 16,
    parameter int LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [31:0]      m_axis_tdata,
    output logic [3:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [LEN_W-1:0] m_pkt_len,
    output logic [LEN_W-1:0] pkt_count,
    output logic [LEN_W-1:0] drop_count,
    output logic             drop_pulse
);
    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_desc_w = 2 * LEN_W;
    localparam logic [c_addr_w:0] c_depth   = (c_addr_w + 1)'(DEPTH);
    localparam logic [c_addr_w:0] c_ptr_one = (c_addr_w + 1)'(1);
    localparam logic [LEN_W-1:0]  c_len_one = LEN_W'(1);

    wr_state_e         r_wr_state;
    wr_state_e         w_wr_state_nxt;
    logic [c_addr_w:0] r_wr_spec;
    logic [c_addr_w:0] r_wr_commit;
    logic [c_addr_w:0] r_rd_ptr;
    logic [c_addr_w:0] w_used;
    logic [LEN_W-1:0]  r_byte_acc;
    logic [LEN_W-1:0]  r_beat_acc;
    logic [LEN_W-1:0]  w_base_bytes;
    logic [LEN_W-1:0]  w_base_beats;
    logic [LEN_W:0]    w_bytes_nxt;
    logic [LEN_W:0]    w_beats_nxt;
    logic              w_ready;
    logic              w_acc;
    logic              w_overflow;
    logic              w_write;
    logic              w_commit;
    logic              w_rollback;
    logic              w_drop_evt;

    axis32_beat_t      r_ram [DEPTH];
    axis32_beat_t      r_head;
    logic              r_head_valid;
    logic [LEN_W-1:0]  r_out_beat;
    logic [LEN_W-1:0]  r_pkt_count;
    logic [LEN_W-1:0]  r_drop_count;
    logic              r_drop_pulse;

    logic              w_len_full;
    logic              w_len_empty;
    logic              w_len_pop;
    logic [c_desc_w-1:0] w_desc;
    logic [LEN_W-1:0]  w_head_bytes;
    logic [LEN_W-1:0]  w_head_beats;
    logic              w_valid;
    logic              w_hs;
    logic              w_last;
    logic              w_fetch;

    // Accumulators are only meaningful in WRITE; the first beat starts from zero.
    assign w_base_bytes = (r_wr_state == WRITE) ? r_byte_acc : '0;
    assign w_base_beats = (r_wr_state == WRITE) ? r_beat_acc : '0;
    assign w_bytes_nxt  = {1'b0, w_base_bytes} + (LEN_W + 1)'(popcount4(s_axis_tkeep));
    assign w_beats_nxt  = {1'b0, w_base_beats} + (LEN_W + 1)'(1);
    assign w_used       = r_wr_spec - r_rd_ptr;
    assign w_overflow   = (w_used == c_depth) || w_bytes_nxt[LEN_W] || w_beats_nxt[LEN_W];

    always_ff @(posedge clk) begin
        if (rst) r_wr_state <= IDLE;
        else     r_wr_state <= w_wr_state_nxt;
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            IDLE, WRITE: begin
                if (w_acc) begin
                    if (s_axis_tlast)    w_wr_state_nxt = IDLE;
                    else if (w_overflow) w_wr_state_nxt = DROP;
                    else                 w_wr_state_nxt = WRITE;
                end
            end
            DROP: begin
                if (w_acc && s_axis_tlast) w_wr_state_nxt = IDLE;
            end
            default: w_wr_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ready    = 1'b0;
        w_write    = 1'b0;
        w_commit   = 1'b0;
        w_rollback = 1'b0;
        w_drop_evt = 1'b0;
        if (!rst) begin
            case (r_wr_state)
                IDLE:        w_ready = !w_len_full;
                WRITE, DROP: w_ready = 1'b1;
                default:     w_ready = 1'b0;
            endcase
        end
        w_acc = s_axis_tvalid && w_ready;
        if (r_wr_state == DROP) begin
            w_drop_evt = w_acc && s_axis_tlast;
        end else if (w_acc) begin
            if (w_overflow) begin
                w_rollback = 1'b1;
                w_drop_evt = s_axis_tlast;
            end else begin
                w_write = 1'b1;
                if (s_axis_tlast) begin
                    // Empty packets, or a full length queue at commit, are discarded.
                    w_commit   = (w_bytes_nxt[LEN_W-1:0] != '0) && (!w_len_full || w_len_pop);
                    w_rollback = !w_commit;
                    w_drop_evt = !w_commit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_spec    <= '0;
            r_wr_commit  <= '0;
            r_byte_acc   <= '0;
            r_beat_acc   <= '0;
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            if (w_rollback)   r_wr_spec <= r_wr_commit;
            else if (w_write) r_wr_spec <= r_wr_spec + c_ptr_one;
            if (w_commit)     r_wr_commit <= r_wr_spec + c_ptr_one;
            if (w_write) begin
                r_byte_acc <= w_bytes_nxt[LEN_W-1:0];
                r_beat_acc <= w_beats_nxt[LEN_W-1:0];
            end
            if (w_drop_evt) r_drop_count <= r_drop_count + c_len_one;
            r_drop_pulse <= w_drop_evt;
        end
    end

    axis_sync_fifo #(
        .WIDTH (c_desc_w),
        .DEPTH (MAX_PKTS)
    ) u_len_q (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_commit),
        .i_wr_data ({w_bytes_nxt[LEN_W-1:0], w_beats_nxt[LEN_W-1:0]}),
        .o_full    (w_len_full),
        .i_rd_en   (w_len_pop),
        .o_rd_data (w_desc),
        .o_empty   (w_len_empty)
    );

    assign w_head_bytes = w_desc[c_desc_w-1:LEN_W];
    assign w_head_beats = w_desc[LEN_W-1:0];
    assign w_valid      = r_head_valid && !w_len_empty;
    assign w_hs         = w_valid && m_axis_tready;
    assign w_last       = w_valid && (r_out_beat == (w_head_beats - c_len_one));
    assign w_len_pop    = w_hs && w_last;
    // Prefetch only from the committed region so uncommitted beats never leak out.
    assign w_fetch      = (!r_head_valid || w_hs) && (r_rd_ptr != r_wr_commit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_head_valid <= 1'b0;
            r_out_beat   <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_fetch) begin
                r_rd_ptr     <= r_rd_ptr + c_ptr_one;
                r_head_valid <= 1'b1;
            end else if (w_hs) begin
                r_head_valid <= 1'b0;
            end
            if (w_len_pop) begin
                r_out_beat  <= '0;
                r_pkt_count <= r_pkt_count + c_len_one;
            end else if (w_hs) begin
                r_out_beat  <= r_out_beat + c_len_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) r_ram[r_wr_spec[c_addr_w-1:0]] <= {s_axis_tkeep, s_axis_tdata};
        if (w_fetch) r_head <= r_ram[r_rd_ptr[c_addr_w-1:0]];
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tdata  = r_head.tdata;
    assign m_axis_tkeep  = r_head.tkeep;
    assign m_axis_tvalid = w_valid;
    assign m_axis_tlast  = w_last;
    assign m_pkt_len     = w_valid ? w_head_bytes : '0;
    assign pkt_count     = r_pkt_count;
    assign drop_count    = r_drop_count;
    assign drop_pulse    = r_drop_pulse;

endmodule
`default_nettype wire

// File: tb/tb_mm2s_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm2s_pkt_fifo
// Description : Directed, table-driven bench for mm2s_pkt_fifo (DEPTH=16).
// Revision    : 1.0
// ============================================================================
module tb_mm2s_pkt_fifo;
    localparam int DEPTH    = 16;
    localparam int MAX_PKTS = 16;
    localparam int LEN_W    = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      s_axis_tdata = '0;
    logic [3:0]       s_axis_tkeep = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic             s_axis_tlast = 1'b0;
    logic [31:0]      m_axis_tdata;
    logic [3:0]       m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             m_axis_tlast;
    logic [LEN_W-1:0] m_pkt_len;
    logic [LEN_W-1:0] pkt_count;
    logic [LEN_W-1:0] drop_count;
    logic             drop_pulse;

    always #5 clk = ~clk;

    mm2s_pkt_fifo #(.DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_pkt_len(m_pkt_len),
        .pkt_count(pkt_count), .drop_count(drop_count), .drop_pulse(drop_pulse)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [15:0] len;
        int          cyc;
    } cap_t;

    typedef struct {
        int         nbeats;
        logic [3:0] last_keep;
        int         exp_len;
        bit         drop;
    } vec_t;

    cap_t cap[$];
    int   cyc = 0;
    int   n_pulses = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_in_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready)
            cap.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_pkt_len, cyc});
        if (drop_pulse) n_pulses++;
    end

    function automatic logic [31:0] pat(input int p, input int b);
        return {8'(p), 8'h5A, 16'(b)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) begin
            check("send_ready_timeout", 32'(s_axis_tready), 32'd1);
            s_axis_tvalid = 1'b0;
            return;
        end
        last_in_cyc = cyc;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int p, input int nb, input logic [3:0] last_keep);
        for (int b = 0; b < nb; b++)
            send_beat(pat(p, b), (b == nb - 1) ? last_keep : 4'hF, b == nb - 1);
    endtask

    task automatic wait_cap(input int n, input int budget, input string name);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(name, 32'(cap.size()), 32'(n));
    endtask

    task automatic check_pkt_beats(input string name, input int first, input int p,
                                   input int nb, input logic [3:0] last_keep, input int exp_len);
        int bad = 0;
        for (int b = 0; b < nb; b++) begin
            if (first + b >= cap.size()) bad++;
            else if (cap[first+b].data !== pat(p, b) ||
                     cap[first+b].keep !== ((b == nb - 1) ? last_keep : 4'hF) ||
                     cap[first+b].last !== (b == nb - 1) ||
                     cap[first+b].len  !== 16'(exp_len)) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_s_tready"},   32'(s_axis_tready), 32'd0);
        check({pfx, "_m_tvalid"},   32'(m_axis_tvalid), 32'd0);
        check({pfx, "_m_tlast"},    32'(m_axis_tlast),  32'd0);
        check({pfx, "_pkt_len"},    32'(m_pkt_len),     32'd0);
        check({pfx, "_pkt_count"},  32'(pkt_count),     32'd0);
        check({pfx, "_drop_count"}, 32'(drop_count),    32'd0);
        check({pfx, "_drop_pulse"}, 32'(drop_pulse),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[8];
        logic [15:0] pc0;
        logic [15:0] dc0;
        int          np0;
        int          bubbles;
        int          c_last;

        vecs[0] = '{1,  4'hF, 4,  1'b0};
        vecs[1] = '{2,  4'h1, 5,  1'b0};
        vecs[2] = '{5,  4'h7, 19, 1'b0};
        vecs[3] = '{1,  4'h0, 0,  1'b1};   // zero-byte packet
        vecs[4] = '{3,  4'h8, 9,  1'b0};
        vecs[5] = '{2,  4'h0, 4,  1'b0};
        vecs[6] = '{20, 4'hF, 0,  1'b1};   // larger than DEPTH
        vecs[7] = '{4,  4'hF, 16, 1'b0};

        tick(3);
        @(negedge clk);
        check_reset("rst");
        rst = 1'b0;
        tick(1);

        // Single packet: latency, contents, length.
        cap.delete();
        send_pkt(1, 3, 4'h3);
        c_last = last_in_cyc;
        wait_cap(3, 50, "t1_beats");
        tick(2);
        check("t1_latency", 32'(cap[0].cyc - c_last), 32'd2);
        check_pkt_beats("t1_data", 0, 1, 3, 4'h3, 10);
        check("t1_pkt_count", 32'(pkt_count), 32'd1);

        for (int i = 0; i < 8; i++) begin
            pc0 = pkt_count;
            dc0 = drop_count;
            np0 = n_pulses;
            cap.delete();
            send_pkt(10 + i, vecs[i].nbeats, vecs[i].last_keep);
            if (vecs[i].drop) tick(10);
            else wait_cap(vecs[i].nbeats, 100, $sformatf("vec%0d_wait", i));
            tick(3);
            check($sformatf("vec%0d_nbeats", i), 32'(cap.size()),
                  vecs[i].drop ? 32'd0 : 32'(vecs[i].nbeats));
            if (!vecs[i].drop)
                check_pkt_beats($sformatf("vec%0d_data", i), 0, 10 + i, vecs[i].nbeats,
                                vecs[i].last_keep, vecs[i].exp_len);
            check($sformatf("vec%0d_pkt_delta", i), 32'(16'(pkt_count - pc0)),
                  vecs[i].drop ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_drop_delta", i), 32'(16'(drop_count - dc0)),
                  vecs[i].drop ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_pulses", i), 32'(n_pulses - np0),
                  vecs[i].drop ? 32'd1 : 32'd0);
        end

        // Back-to-back: 4 x 8 beats must leave as 32 contiguous beats.
        cap.delete();
        pc0 = pkt_count;
        for (int p = 0; p < 4; p++) send_pkt(20 + p, 8, 4'hF);
        wait_cap(32, 100, "t2_beats");
        tick(2);
        bubbles = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i].cyc != cap[0].cyc + i) bubbles++;
        check("t2_bubbles", 32'(bubbles), 32'd0);
        for (int p = 0; p < 4; p++)
            check_pkt_beats($sformatf("t2_pkt%0d", p), 8 * p, 20 + p, 8, 4'hF, 32);
        check("t2_pkt_delta", 32'(16'(pkt_count - pc0)), 32'd4);

        // Backpressure: the length queue fills and input stalls in IDLE.
        cap.delete();
        pc0 = pkt_count;
        m_axis_tready = 1'b0;
        for (int p = 0; p < 16; p++) send_pkt(40 + p, 1, 4'hF);
        tick(2);
        @(negedge clk);
        check("t4_s_tready_full", 32'(s_axis_tready), 32'd0);
        check("t4_m_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t4_head_data", m_axis_tdata, pat(40, 0));
        check("t4_head_len", 32'(m_pkt_len), 32'd4);
        tick(3);
        @(negedge clk);
        check("t4_hold_data", m_axis_tdata, pat(40, 0));
        check("t4_hold_last", 32'(m_axis_tlast), 32'd1);
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        wait_cap(16, 100, "t4_beats");
        tick(2);
        for (int p = 0; p < 16; p++)
            check_pkt_beats($sformatf("t4_pkt%0d", p), p, 40 + p, 1, 4'hF, 4);
        check("t4_pkt_delta", 32'(16'(pkt_count - pc0)), 32'd16);
        check("t4_s_tready_after", 32'(s_axis_tready), 32'd1);

        // Reset in the middle of a packet.
        send_beat(pat(60, 0), 4'hF, 1'b0);
        send_beat(pat(60, 1), 4'hF, 1'b0);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check_reset("t6");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        cap.delete();
        send_pkt(61, 2, 4'hF);
        wait_cap(2, 50, "t6_beats");
        tick(3);
        check("t6_only_two", 32'(cap.size()), 32'd2);
        check_pkt_beats("t6_data", 0, 61, 2, 4'hF, 8);
        check("t6_pkt_count", 32'(pkt_count), 32'd1);
        check("t6_drop_count", 32'(drop_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
